// File: rtl/add16_sequencer_pkg.sv
// Shared types and helpers for the byte-serial add/subtract sequencer.
// State encodings match the legacy add_seq_defs.vh values.
package add16_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Byte-counter width; a single-byte build still needs one bit of storage.
  function automatic int idx_w(input int nbytes);
    return (nbytes <= 1) ? 1 : $clog2(nbytes);
  endfunction

endpackage

// File: rtl/CLA_8bit.sv
// 8-bit carry-lookahead adder built from two 4-bit lookahead groups
// joined by a second level of group generate/propagate.
module CLA_8bit (
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  input  logic       i_cin,
  output logic [7:0] o_sum,
  output logic       o_cout
);

  logic [7:0] w_p;
  logic [7:0] w_g;
  logic [4:0] w_lo;
  logic [4:0] w_hi;
  logic       w_c4;
  logic [7:0] w_c;

  // Returns {group_g, group_p, c3, c2, c1} for one 4-bit slice.
  function automatic logic [4:0] cla4(input logic [3:0] p, input logic [3:0] g,
                                      input logic c0);
    logic c1, c2, c3, gg, gp;
    c1 = g[0] | (p[0] & c0);
    c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    gp = &p;
    return {gg, gp, c3, c2, c1};
  endfunction

  assign w_p  = i_a ^ i_b;
  assign w_g  = i_a & i_b;
  assign w_lo = cla4(w_p[3:0], w_g[3:0], i_cin);
  assign w_c4 = w_lo[4] | (w_lo[3] & i_cin);
  assign w_hi = cla4(w_p[7:4], w_g[7:4], w_c4);

  assign w_c   = {w_hi[2:0], w_c4, w_lo[2:0], i_cin};
  assign o_sum = w_p ^ w_c;
  assign o_cout = w_hi[4] | (w_hi[3] & w_lo[4]) | (w_hi[3] & w_lo[3] & i_cin);

endmodule

// File: rtl/add16_sequencer.sv
// Byte-serial W-bit add/subtract on one shared 8-bit CLA, LSB first, carry
// chained through a register; returns N/Z/C/V and a page-cross flag.
module add16_sequencer
  import add16_sequencer_pkg::*;
#(
  parameter int NBYTES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [8*NBYTES-1:0] in_a,
  input  logic [8*NBYTES-1:0] in_b,
  input  logic                in_cin,
  input  logic                in_sub,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [8*NBYTES-1:0] out_sum,
  output logic                out_c,
  output logic                out_v,
  output logic                out_n,
  output logic                out_z,
  output logic                out_page
);

  localparam int W  = 8 * NBYTES;
  localparam int IW = idx_w(NBYTES);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [IW-1:0] r_idx;
  logic          r_carry;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_bx;
  logic [W-1:0]  r_acc;
  logic          r_page_q;
  logic [W-1:0]  r_sum;
  logic          r_c;
  logic          r_v;
  logic          r_n;
  logic          r_z;
  logic          r_page;

  logic          w_accept;
  logic          w_last;
  logic [IW+2:0] w_base;
  logic [7:0]    w_a_byte;
  logic [7:0]    w_b_byte;
  logic [7:0]    w_sum_byte;
  logic          w_cout;
  logic [W-1:0]  w_sum_full;
  logic          w_page_full;

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign w_accept  = in_valid && in_ready && !flush;
  assign w_last    = (r_idx == IW'(NBYTES - 1));
  assign w_base    = {r_idx, 3'b000};

  assign w_a_byte = r_a[w_base +: 8];
  assign w_b_byte = r_bx[w_base +: 8];

  CLA_8bit u_cla (
    .i_a    (w_a_byte),
    .i_b    (w_b_byte),
    .i_cin  (r_carry),
    .o_sum  (w_sum_byte),
    .o_cout (w_cout)
  );

  // Partial result with the current byte merged in; committed only on the
  // last byte so an aborted op never disturbs the visible result.
  always_comb begin
    w_sum_full = r_acc;
    w_sum_full[w_base +: 8] = w_sum_byte;
    w_page_full = (r_idx == '0) ? w_cout : r_page_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept)  w_state_nxt = ST_RUN;
      ST_RUN:  if (w_last)    w_state_nxt = ST_DONE;
      ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
      default:                w_state_nxt = ST_IDLE;
    endcase
    if (flush) w_state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx    <= '0;
      r_carry  <= 1'b0;
      r_a      <= '0;
      r_bx     <= '0;
      r_acc    <= '0;
      r_page_q <= 1'b0;
      r_sum    <= '0;
      r_c      <= 1'b0;
      r_v      <= 1'b0;
      r_n      <= 1'b0;
      r_z      <= 1'b0;
      r_page   <= 1'b0;
    end else if (flush) begin
      r_idx <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_a     <= in_a;
            r_bx    <= in_b ^ {W{in_sub}};
            r_carry <= in_cin;
            r_idx   <= '0;
          end
        end
        ST_RUN: begin
          r_acc    <= w_sum_full;
          r_carry  <= w_cout;
          r_page_q <= w_page_full;
          if (w_last) begin
            r_sum  <= w_sum_full;
            r_page <= w_page_full;
            r_c    <= w_cout;
            r_v    <= (r_a[W-1] == r_bx[W-1]) && (w_sum_full[W-1] != r_a[W-1]);
            r_n    <= w_sum_full[W-1];
            r_z    <= (w_sum_full == '0);
            r_idx  <= '0;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_sum  = r_sum;
  assign out_c    = r_c;
  assign out_v    = r_v;
  assign out_n    = r_n;
  assign out_z    = r_z;
  assign out_page = r_page;

endmodule

// File: tb/tb_add16_sequencer.sv
// Directed bench for add16_sequencer with NBYTES=2: arithmetic/flag vectors,
// latency, backpressure, flush and async-reset aborts.
module tb_add16_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_a = '0;
  logic [15:0] in_b = '0;
  logic        in_cin = 1'b0;
  logic        in_sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_sum;
  logic        out_c, out_v, out_n, out_z, out_page;

  int checks = 0;
  int failures = 0;

  add16_sequencer #(.NBYTES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_c     (out_c),
    .out_v     (out_v),
    .out_n     (out_n),
    .out_z     (out_z),
    .out_page  (out_page)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one op in IDLE and checks the exact two-cycle latency to DONE.
  task automatic op_to_done(input string tag, input logic [15:0] a, input logic [15:0] b,
                            input logic cin, input logic sub);
    in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
    chk({tag, ".in_ready"}, in_ready, 1);
    step();
    in_valid = 1'b0;
    chk({tag, ".lat0"}, out_valid, 0);
    step();
    chk({tag, ".lat1"}, out_valid, 0);
    step();
    chk({tag, ".lat2"}, out_valid, 1);
  endtask

  task automatic chk_res(input string tag, input logic [15:0] s, input logic c,
                         input logic v, input logic n, input logic z, input logic pg);
    chk({tag, ".sum"}, out_sum, s);
    chk({tag, ".c"}, out_c, c);
    chk({tag, ".v"}, out_v, v);
    chk({tag, ".n"}, out_n, n);
    chk({tag, ".z"}, out_z, z);
    chk({tag, ".page"}, out_page, pg);
  endtask

  task automatic release_done(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, ".idle_ready"}, in_ready, 1);
    chk({tag, ".idle_valid"}, out_valid, 0);
  endtask

  initial begin
    #2;
    chk("rst.in_ready", in_ready, 1);
    chk("rst.out_valid", out_valid, 0);
    chk_res("rst", 16'h0000, 0, 0, 0, 0, 0);
    #10 rst = 1'b0;
    step();

    op_to_done("t1", 16'h12FF, 16'h0001, 0, 0);
    chk_res("t1", 16'h1300, 0, 0, 0, 0, 1);
    release_done("t1");

    op_to_done("t2", 16'h7FFF, 16'h0001, 0, 0);
    chk_res("t2", 16'h8000, 0, 1, 1, 0, 1);
    release_done("t2");

    op_to_done("t3", 16'h0000, 16'h0001, 1, 1);
    chk_res("t3", 16'hFFFF, 0, 0, 1, 0, 0);
    release_done("t3");

    op_to_done("t3b", 16'h1300, 16'h0001, 1, 1);
    chk_res("t3b", 16'h12FF, 1, 0, 0, 0, 0);
    release_done("t3b");

    op_to_done("t4", 16'hFFFF, 16'h0001, 0, 0);
    chk_res("t4", 16'h0000, 1, 0, 0, 1, 1);
    release_done("t4");

    // Backpressure: result must hold while a competing op is offered.
    op_to_done("t5", 16'h12FF, 16'h0001, 0, 0);
    in_a = 16'hAAAA; in_b = 16'h5555; in_cin = 1'b1; in_sub = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t5.hold_valid", out_valid, 1);
      chk("t5.hold_ready", in_ready, 0);
      chk_res("t5.hold", 16'h1300, 0, 0, 0, 0, 1);
    end
    in_valid = 1'b0;
    release_done("t5");
    chk("t5.kept_sum", out_sum, 16'h1300);
    op_to_done("t5n", 16'h00FF, 16'h00FF, 1, 0);
    chk_res("t5n", 16'h01FF, 0, 0, 0, 0, 1);
    release_done("t5n");

    // Flush while the high byte is pending.
    in_a = 16'h1111; in_b = 16'h1111; in_cin = 1'b0; in_sub = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("t6f.in_ready", in_ready, 1);
    chk("t6f.out_valid", out_valid, 0);
    chk("t6f.sum_kept", out_sum, 16'h01FF);
    chk("t6f.page_kept", out_page, 1);
    step();
    chk("t6f.no_valid1", out_valid, 0);
    step();
    chk("t6f.no_valid2", out_valid, 0);

    // Flush with in_valid in IDLE must not accept.
    in_valid = 1'b1; flush = 1'b1;
    step();
    in_valid = 1'b0; flush = 1'b0;
    chk("t6g.no_accept", in_ready, 1);

    // Asynchronous reset while the high byte is pending.
    in_a = 16'h2222; in_b = 16'h3333; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    #1;
    chk("t6r.in_ready", in_ready, 1);
    chk("t6r.out_valid", out_valid, 0);
    chk("t6r.sum", out_sum, 16'h0000);
    chk("t6r.page", out_page, 0);
    step();
    rst = 1'b0;
    step();
    chk("t6r.no_valid1", out_valid, 0);
    step();
    chk("t6r.no_valid2", out_valid, 0);

    op_to_done("t6n", 16'h0102, 16'h0304, 0, 0);
    chk_res("t6n", 16'h0406, 0, 0, 0, 0, 0);
    release_done("t6n");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
